// File: rtl/tdm_demux1to4.sv
// Receive-side 1-to-4 time-division demultiplexer: locks on a lane-0 sync marker,
// collects four serial lane samples and publishes them in parallel with a valid pulse.
module tdm_demux1to4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enbl,
  input  logic               sync,
  input  logic [WIDTH-1:0]   din,
  output logic [1:0]         s,
  output logic [4*WIDTH-1:0] d,
  output logic               valid,
  output logic               err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  logic [3*WIDTH-1:0]   shadow_q, shadow_d;
  logic [4*WIDTH-1:0]   d_q, d_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  // Next-state: slot tracking, shadow capture, frame publish and resync detection
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (enbl) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            shadow_d[0 +: WIDTH] = din;
            slot_d               = 2'd1;
            state_d              = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          case (slot_q)
            2'd0: begin
              shadow_d[0 +: WIDTH] = din;
              slot_d               = 2'd1;
            end
            2'd1, 2'd2: begin
              // A sync here means the transmitter restarted; drop the partial frame
              if (sync) begin
                shadow_d[0 +: WIDTH] = din;
                slot_d               = 2'd1;
                err_d                = 1'b1;
              end else if (slot_q == 2'd1) begin
                shadow_d[WIDTH +: WIDTH] = din;
                slot_d                   = 2'd2;
              end else begin
                shadow_d[2*WIDTH +: WIDTH] = din;
                slot_d                     = 2'd3;
              end
            end
            default: begin
              d_d     = {din, shadow_q};
              slot_d  = 2'd0;
              valid_d = 1'b1;
            end
          endcase
        end
        default: begin
          state_d = IDLE;
          slot_d  = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= 2'd0;
      shadow_q <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      d_q      <= d_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign s     = slot_q;
  assign d     = d_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Bench for tdm_demux1to4 (WIDTH=1): directed scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_tdm_demux1to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enbl = 1'b0;
  logic       sync = 1'b0;
  logic [0:0] din = 1'b0;
  logic [1:0] s;
  logic [3:0] d;
  logic       valid;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit         locked;
  bit         partial[$];
  logic [3:0] exp_d;
  logic       exp_valid;
  logic       exp_err;
  bit         cmp_en = 1'b0;

  tdm_demux1to4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .enbl(enbl), .sync(sync), .din(din),
    .s(s), .d(d), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_s();
    return 2'(partial.size());
  endfunction

  task automatic model_reset();
    locked = 1'b0;
    partial.delete();
    exp_d = 4'd0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
  endtask

  // Behaviour of one rising edge, expressed in terms of frames being collected
  task automatic model_step(input bit e, input bit sy, input bit di);
    exp_valid = 1'b0;
    exp_err = 1'b0;
    if (!e) return;
    if (!locked) begin
      if (sy) begin
        locked = 1'b1;
        partial.push_back(di);
      end
      return;
    end
    if (sy && (partial.size() == 1 || partial.size() == 2)) begin
      partial.delete();
      partial.push_back(di);
      exp_err = 1'b1;
      return;
    end
    partial.push_back(di);
    if (partial.size() == 4) begin
      for (int k = 0; k < 4; k++) exp_d[k] = partial[k];
      partial.delete();
      exp_valid = 1'b1;
    end
  endtask

  task automatic cyc(input bit e, input bit sy, input bit di);
    @(negedge clk);
    enbl = e; sync = sy; din = di;
    @(posedge clk);
    model_step(e, sy, di);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enbl = 1'b0; sync = 1'b0; din = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare process: outputs vs model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s", 32'(s), 32'(exp_s()));
      chk("d", 32'(d), 32'(exp_d));
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("err", 32'(err), 32'(exp_err));
      if (valid && err) chk("valid_err_exclusive", 32'd1, 32'd0);
    end
  end

  initial begin
    logic [3:0] frm;
    int vcnt;
    int ecnt;
    model_reset();
    #2;
    cmp_en = 1'b1;
    do_reset();

    // Unlocked input ignored
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'(i & 1));
    chk("unlocked_s", 32'(s), 32'd0);
    chk("unlocked_d", 32'(d), 32'd0);

    // Basic frame 0,1,0,1
    cyc(1'b1, 1'b1, 1'b0); chk("t1_s1", 32'(s), 32'd1);
    cyc(1'b1, 1'b0, 1'b1); chk("t1_s2", 32'(s), 32'd2);
    cyc(1'b1, 1'b0, 1'b0); chk("t1_s3", 32'(s), 32'd3);
    chk("t1_novalid", 32'(valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t1_d", 32'(d), 32'hA);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_s0", 32'(s), 32'd0);

    // Back-to-back frames without sync
    frm = 4'b1011;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, frm[k]);
    chk("t2_d1", 32'(d), 32'hB);
    chk("t2_valid1", 32'(valid), 32'd1);
    frm = 4'b0011;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, frm[k]);
    chk("t2_d2", 32'(d), 32'h3);
    chk("t2_valid2", 32'(valid), 32'd1);

    // Enable gap between lane 1 and lane 2
    frm = 4'b1011;
    cyc(1'b1, 1'b1, frm[0]);
    cyc(1'b1, 1'b0, frm[1]);
    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("t3_gap_s", 32'(s), 32'd2);
      chk("t3_gap_d", 32'(d), 32'h3);
    end
    cyc(1'b1, 1'b0, frm[2]);
    cyc(1'b1, 1'b0, frm[3]);
    chk("t3_d", 32'(d), 32'hB);
    chk("t3_valid", 32'(valid), 32'd1);

    // Resync at slot 2
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_s", 32'(s), 32'd1);
    chk("t4_d_held", 32'(d), 32'hB);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t4_err_once", 32'(err), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t4_d_still", 32'(d), 32'hB);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t4_d", 32'(d), 32'hF);
    chk("t4_valid", 32'(valid), 32'd1);

    // Asynchronous reset after lane 2
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_d", 32'(d), 32'd0);
    chk("t6_rst_s", 32'(s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frm = 4'b1000;
    cyc(1'b1, 1'b1, frm[0]);
    for (int k = 1; k < 4; k++) cyc(1'b1, 1'b0, frm[k]);
    chk("t6_d", 32'(d), 32'h8);
    chk("t6_valid", 32'(valid), 32'd1);

    // Random traffic, occasional asynchronous resets
    vcnt = 0;
    ecnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'($urandom));
        if (valid) vcnt++;
        if (err) ecnt++;
      end
    end
    if (vcnt == 0) chk("rand_saw_valid", 32'd0, 32'd1);
    if (ecnt == 0) chk("rand_saw_err", 32'd0, 32'd1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux1to4.md
# tdm_demux1to4

Sequential 1-to-4 time-division demultiplexer: the receive-side counterpart of the 4-to-1 select mux in the datapath library. It takes one serialized lane stream, with one lane sample per enabled clock and a frame-start marker on lane 0. It tracks the slot number internally, assembles the four samples of a frame, and publishes them in parallel with a one-cycle valid pulse. Typical use is to reconstruct `d` words that were serialized by stepping a mux select `s` through 0..3.

## Interface
Parameters:
- `WIDTH`, default 1: bits per lane sample.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enbl`, in, 1: sample enable. When low, the block holds all state and captures nothing.
- `sync`, in, 1: frame-start marker. High means `din` carries lane 0 of a new frame.
- `din`, in, WIDTH: serial lane sample.
- `s`, out, 2: slot index the next enabled sample will be written to.
- `d`, out, 4*WIDTH: last complete frame. Lane k occupies `d[k*WIDTH +: WIDTH]`.
- `valid`, out, 1: one-cycle pulse when `d` has just been updated.
- `err`, out, 1: one-cycle pulse when `sync` arrives mid-frame.

## Operation
- States:
  - IDLE: unlocked, waiting for the first `sync`.
  - RUN: locked, slot counter is free-running on `enbl`.
- Internal storage: a 3-lane shadow register for lanes 0..2 and a 2-bit slot counter. `s` is driven directly from the slot counter.
- IDLE, `enbl`=1 and `sync`=1:
  - write `din` to shadow lane 0;
  - slot becomes 1;
  - go to RUN.
- IDLE, any other input: no change. `din` is ignored.
- RUN, `enbl`=1 and `sync`=0:
  - write `din` to the shadow lane for the current slot;
  - slot increments modulo 4.
- RUN, `enbl`=1, slot=3, and `sync`=0 or 1 (frame complete):
  - `d` is loaded with shadow lanes 0..2 plus `din` as lane 3;
  - slot wraps to 0;
  - `valid` pulses;
  - `err` does not pulse.
- RUN, `enbl`=1, slot=0, `sync`=1: normal frame start. No error.
- RUN, `enbl`=1, slot=0, `sync`=0: accepted as lane 0. Once locked, `sync` is optional.
- RUN, `enbl`=1, slot=1 or 2, `sync`=1 (resync):
  - the partial frame is discarded and `d` is unchanged;
  - `din` becomes shadow lane 0;
  - slot becomes 1;
  - `err` pulses.
- `enbl`=0 in any state: slot, state, shadow and `d` all hold. `valid` and `err` are 0.
- `d` changes only on frame completion. Its previous value is held indefinitely otherwise.
- The block never returns to IDLE except through reset.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `s`=0, shadow=0, `d`=0, `valid`=0, `err`=0.
- Reset deasserted mid-frame: the partial frame is lost. The block needs a fresh `sync` to lock.
- Latency: the rising edge that samples lane 3 also updates `d` and raises `valid`. `valid` is high for exactly the cycle after that edge.
- Minimum frame period: 4 consecutive enabled cycles. Back-to-back frames produce `valid` every 4th cycle.
- Gaps: `enbl` low cycles inside a frame stretch it. The gaps do not corrupt it.
- `valid` and `err` are registered. They are never both high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=1.
1. Reset then basic frame: `enbl`=1, `sync`=1 with `din`=0, then `din`=1, 0, 1 -> `d`=4'b1010, `valid` high for 1 cycle, `s` sequence 0,1,2,3,0.
2. Back-to-back frames, no `sync` after lock: 1,1,0,1 then 1,1,0,0 -> `d`=4'b1011 then 4'b0011, `valid` every 4th cycle, `err`=0 throughout.
3. `enbl` gaps: `enbl` low for 3 cycles between lane 1 and lane 2 of frame 1,1,0,1 -> `s` holds 2 during the gap, `valid` arrives 3 cycles late, `d`=4'b1011.
4. Resync: `sync` at slot 2 carrying `din`=1, then 1,1,1 -> `err` pulses once, `d` unchanged until the frame completes, then `d`=4'b1111, `s` goes 1 after the resync.
5. Unlocked input ignored: before any `sync`, toggle `din` for 10 enabled cycles -> `s`=0, `d`=0, `valid`=0 throughout.
6. Asynchronous reset mid-frame: assert `rst_n`=0 between clock edges after lane 2 -> `d`=0 and `s`=0 immediately. A subsequent `sync` frame 0,0,0,1 yields `d`=4'b1000.
